btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Parametrised front-panel input conditioner for N_BTN push-buttons in the 100 MHz domain. It replaces the bare `btn` capture register between the board pins and the game core (snake direction, reset, future menus). Per channel it provides:
- metastability synchronisation,
- counter-based debounce,
- a clean level, one-cycle press and release pulses,
- a latched one-hot "last pressed" vector for direction control.

## Interface
Parameters:
- N_BTN, 4, number of button channels (1..16).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (≥1; 10 ms at 100 MHz).
- REPEAT_DELAY, 50000000, cycles of hold before first auto-repeat pulse (≥1; used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (≥1; used only with BTN_AUTOREPEAT_EN).

Ports:
- CLK100MHZ  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  asynchronous raw button pins, active-high.
- btn_level  output  N_BTN  debounced level.
- btn_press  output  N_BTN  one-cycle pulse per accepted press (and per repeat).
- btn_release  output  N_BTN  one-cycle pulse per accepted release.
- any_press  output  1  OR of btn_press.
- dir_onehot  output  N_BTN  one-hot index of most recently pressed channel; 0 until first press.

## Operation
- Per channel: two-flop synchroniser sync1→sync2, stable register, debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
- Each cycle, compare sync2 against stable:
  - sync2 == stable: counter cleared to 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable ← sync2, counter ← 0. btn_press (0→1) or btn_release (1→0) asserts in the same cycle stable first shows the new value.
- Glitch shorter than DEBOUNCE_CYCLES (sync2 returns to stable early): counter clears; no output change.
- btn_level = stable; btn_press/btn_release registered; never both high on one channel.
- dir_onehot: on a cycle with any btn_press bit set, load the lowest-index asserted press bit as one-hot. Otherwise hold. Releases never change it.
- Simultaneous presses on several channels: all press bits pulse; dir_onehot takes the lowest index.
- Reset: all sync, stable, counter, repeat state and all outputs cleared to 0 on the next edge.
- Button held through reset: treated as a fresh press, accepted DEBOUNCE_CYCLES+2 edges after reset deasserts.

## Timing
- Latency: raw change settling before edge 1 → btn_level/btn_press/btn_release update after edge DEBOUNCE_CYCLES+2.
- Pulses are exactly one cycle wide. Consecutive press pulses on one channel are at least 2·DEBOUNCE_CYCLES cycles apart without auto-repeat.
- any_press is combinational OR of registered btn_press (same cycle).
- dir_onehot updates one edge after the press pulse cycle.

## Configuration
- Macro BTN_AUTOREPEAT_EN.
- Defined: per-channel repeat counter of width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1), cleared on press pulse and on release.
  - While btn_level stays 1, an extra btn_press pulse fires REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles.
  - Repeat pulses also update dir_onehot and any_press.
  - Release stops repetition immediately; no pulse in the release cycle.
- Undefined: no repeat logic synthesised. Exactly one btn_press per accepted press. REPEAT_* ignored.

## Test plan
Bench parameters: N_BTN=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.

- Clean press: raise btn_raw[0] before edge 1 and hold → btn_level[0]=1 and btn_press[0]=1 after edge 6. btn_press[0]=0 after edge 7. dir_onehot=3'b001 after edge 7.
- Bounce: btn_raw[1] high 3 cycles, low 1, high 3, low → no btn_level/btn_press change. Counter returns to 0.
- Simultaneous: raise btn_raw[2] and btn_raw[1] on the same cycle → btn_press=3'b110 for one cycle. dir_onehot=3'b010. any_press=1 that cycle only.
- Release: drop btn_raw[0] after accepted press → btn_release[0]=1 exactly 6 edges later, btn_level[0]=0. dir_onehot unchanged.
- Reset mid-count: assert reset with btn_raw[0] held and counter at 2 → all outputs 0 next edge. After reset drops, btn_press[0] asserts 6 edges later.
- With BTN_AUTOREPEAT_EN: hold btn_raw[0] for 40 cycles → press pulses at acceptance cycle T, T+10, T+13, T+16…, until release. Without the macro: a single pulse at T.

Source files
------------

// File: rtl/btn_conditioner_if.sv
// Front-panel button bundle between the board pins and the game core.
// The board side drives btn_raw; the conditioner drives the cleaned outputs.
interface btn_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_press;
    logic [N_BTN-1:0] dir_onehot;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_press,
        input  dir_onehot
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_press,
        output dir_onehot
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button synchroniser, counter debounce, press/release pulses and last-pressed one-hot.
// Optional auto-repeat of press pulses while held is compiled in with `define BTN_AUTOREPEAT_EN.
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input logic              CLK100MHZ,
    input logic              reset,
    btn_conditioner_if.slave btn
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

    if (N_BTN < 1 || N_BTN > 16 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("btn_conditioner: parameter out of range");
    end

    function automatic logic [N_BTN-1:0] lowest_onehot(input logic [N_BTN-1:0] v);
        logic [N_BTN-1:0] neg;
        neg = ~v + N_BTN'(1);
        return v & neg;
    endfunction

    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] release_v;
    logic [N_BTN-1:0] dir_p4;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic             sync1_p0;
        logic             sync2_p1;
        logic             stable_p2;
        logic [CNT_W-1:0] cnt_p2;
        logic             press_p3;
        logic             release_p3;
        logic             accept_c;
        logic             rpt_fire_c;

        // A change is accepted on the edge that would take the counter to DEBOUNCE_CYCLES.
        assign accept_c = (sync2_p1 != stable_p2) && (cnt_p2 == CNT_LAST);

        // stage p0/p1: two-flop synchroniser; p2: debounce; p3: edge pulses
        always_ff @(posedge CLK100MHZ) begin
            if (reset) begin
                sync1_p0   <= 1'b0;
                sync2_p1   <= 1'b0;
                stable_p2  <= 1'b0;
                cnt_p2     <= '0;
                press_p3   <= 1'b0;
                release_p3 <= 1'b0;
            end else begin
                sync1_p0 <= btn.btn_raw[i];
                sync2_p1 <= sync1_p0;
                if (sync2_p1 == stable_p2) begin
                    cnt_p2 <= '0;
                end else if (accept_c) begin
                    stable_p2 <= sync2_p1;
                    cnt_p2    <= '0;
                end else begin
                    cnt_p2 <= cnt_p2 + CNT_W'(1);
                end
                press_p3   <= (accept_c && sync2_p1) || rpt_fire_c;
                release_p3 <= accept_c && !sync2_p1;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_cnt_p2;
        logic             rpt_first_p2;
        logic [RPT_W-1:0] rpt_last_c;

        // The accept guard keeps the release cycle free of a repeat pulse.
        assign rpt_last_c = rpt_first_p2 ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
        assign rpt_fire_c = stable_p2 && !accept_c && (rpt_cnt_p2 == rpt_last_c);

        always_ff @(posedge CLK100MHZ) begin
            if (reset) begin
                rpt_cnt_p2   <= '0;
                rpt_first_p2 <= 1'b0;
            end else if (accept_c) begin
                rpt_cnt_p2   <= '0;
                rpt_first_p2 <= 1'b1;
            end else if (rpt_fire_c) begin
                rpt_cnt_p2   <= '0;
                rpt_first_p2 <= 1'b0;
            end else if (stable_p2) begin
                rpt_cnt_p2 <= rpt_cnt_p2 + RPT_W'(1);
            end
        end
`else
        assign rpt_fire_c = 1'b0;
`endif

        assign level_v[i]   = stable_p2;
        assign press_v[i]   = press_p3;
        assign release_v[i] = release_p3;
    end

    // stage p4: last-pressed direction, lowest index wins on simultaneous presses
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            dir_p4 <= '0;
        end else if (|press_v) begin
            dir_p4 <= lowest_onehot(press_v);
        end
    end

    assign btn.btn_level   = level_v;
    assign btn.btn_press   = press_v;
    assign btn.btn_release = release_v;
    assign btn.any_press   = |press_v;
    assign btn.dir_onehot  = dir_p4;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with N_BTN=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_btn_conditioner;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    btn_conditioner_if #(.N_BTN(3)) bif ();

    btn_conditioner #(
        .N_BTN(3),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .CLK100MHZ(clk),
        .reset(reset),
        .btn(bif)
    );

    typedef struct packed {
        logic [2:0] level;
        logic [2:0] press;
        logic [2:0] rel;
        logic       any;
        logic [2:0] dir;
    } obs_t;

    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic obs_t sample();
        obs_t o;
        o.level = bif.btn_level;
        o.press = bif.btn_press;
        o.rel   = bif.btn_release;
        o.any   = bif.any_press;
        o.dir   = bif.dir_onehot;
        return o;
    endfunction

    function automatic obs_t mk(input logic [2:0] l, input logic [2:0] p,
                                input logic [2:0] r, input logic [2:0] d);
        obs_t o;
        o.level = l;
        o.press = p;
        o.rel   = r;
        o.any   = |p;
        o.dir   = d;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("lvl=%b prs=%b rel=%b any=%b dir=%b", o.level, o.press, o.rel, o.any, o.dir);
    endfunction

    task automatic do_reset();
        reset       = 1'b1;
        bif.btn_raw = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, want;
        reset       = 1'b1;
        bif.btn_raw = 3'b111;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
        bif.btn_raw = 3'b000;
        reset       = 1'b0;
    endtask

    task automatic test_clean_press();
        obs_t got, want;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            bif.btn_raw = 3'b001;
            sb.push_back(mk((k >= 6) ? 3'b001 : 3'b000, (k == 6) ? 3'b001 : 3'b000,
                            3'b000, (k >= 7) ? 3'b001 : 3'b000));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL clean_press k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_release();
        obs_t got, want;
        for (int k = 1; k <= 8; k++) begin
            bif.btn_raw = 3'b000;
            sb.push_back(mk((k < 6) ? 3'b001 : 3'b000, 3'b000,
                            (k == 6) ? 3'b001 : 3'b000, 3'b001));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL release k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_bounce();
        obs_t        got, want;
        logic [11:0] pat;
        pat = 12'b000001110111;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            bif.btn_raw = {1'b0, pat[k-1], 1'b0};
            sb.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL bounce k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
        // a clean press right after the glitches still needs the full debounce time
        for (int k = 1; k <= 7; k++) begin
            bif.btn_raw = 3'b010;
            sb.push_back(mk((k >= 6) ? 3'b010 : 3'b000, (k == 6) ? 3'b010 : 3'b000,
                            3'b000, (k >= 7) ? 3'b010 : 3'b000));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL bounce_then_press k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_simultaneous();
        obs_t got, want;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            bif.btn_raw = 3'b110;
            sb.push_back(mk((k >= 6) ? 3'b110 : 3'b000, (k == 6) ? 3'b110 : 3'b000,
                            3'b000, (k >= 7) ? 3'b010 : 3'b000));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL simultaneous k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
        for (int k = 1; k <= 7; k++) begin
            bif.btn_raw = 3'b111;
            sb.push_back(mk((k >= 6) ? 3'b111 : 3'b110, (k == 6) ? 3'b001 : 3'b000,
                            3'b000, (k >= 7) ? 3'b001 : 3'b010));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL second_press k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_mid_count();
        obs_t got, want;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            bif.btn_raw = 3'b001;
            sb.push_back(mk((k >= 6) ? 3'b001 : 3'b000, (k == 6) ? 3'b001 : 3'b000,
                            3'b000, (k >= 7) ? 3'b001 : 3'b000));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL pre_reset_press k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
        for (int k = 1; k <= 4; k++) begin
            bif.btn_raw = 3'b101;
            sb.push_back(mk(3'b001, 3'b000, 3'b000, 3'b001));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mid_count k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
        reset = 1'b1;
        sb.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000));
        @(posedge clk); #1;
        got = sample(); want = sb.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_mid_count got %s want %s", fmt(got), fmt(want));
        end
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            bif.btn_raw = 3'b101;
            sb.push_back(mk((k >= 6) ? 3'b101 : 3'b000, (k == 6) ? 3'b101 : 3'b000,
                            3'b000, (k >= 7) ? 3'b001 : 3'b000));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL held_through_reset k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_repeat();
        obs_t       got, want;
        logic [2:0] p;
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            bif.btn_raw = (k <= 40) ? 3'b001 : 3'b000;
            p = (k == 6) ? 3'b001 : 3'b000;
`ifdef BTN_AUTOREPEAT_EN
            if (k >= 16 && k < 46 && ((k - 16) % 3) == 0) p = 3'b001;
`endif
            sb.push_back(mk((k >= 6 && k < 46) ? 3'b001 : 3'b000, p,
                            (k == 46) ? 3'b001 : 3'b000, (k >= 7) ? 3'b001 : 3'b000));
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL hold_repeat k=%0d got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time (vectors %0d)", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        bif.btn_raw = 3'b000;
        #1;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_repeat();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
